// File: rtl/multiplica_galois_seq.sv
// Sequential GF(2^WIDTH) shift-and-add multiplier with a start/done handshake.
// Define MULTIPLICA_GALOIS_EARLY_EN to end CALC once no multiplier bits remain.
module multiplica_galois_seq #(
  parameter int unsigned          WIDTH = 8,
  parameter logic [WIDTH-1:0]     POLY  = WIDTH'(8'h1B)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inicio,
  input  logic [WIDTH-1:0] e,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] s,
  output logic             ocupado,
  output logic             pronto
);

  localparam int unsigned      CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] acc_n;
  logic [WIDTH-1:0] a_n;
  logic [WIDTH-1:0] b_n;
  logic             last;

  always_comb begin
    acc_n = acc ^ (b[0] ? a : '0);
    // xtime: shift out the top bit and fold it back in through the polynomial
    a_n   = {a[WIDTH-2:0], 1'b0} ^ (a[WIDTH-1] ? POLY : '0);
    b_n   = b >> 1;
`ifdef MULTIPLICA_GALOIS_EARLY_EN
    last  = (cnt == LAST) || (b_n == '0);
`else
    last  = (cnt == LAST);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a     <= '0;
      b     <= '0;
      acc   <= '0;
      cnt   <= '0;
      s     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (inicio) begin
            a     <= e;
            b     <= c;
            acc   <= '0;
            cnt   <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          a   <= a_n;
          b   <= b_n;
          cnt <= cnt + CW'(1);
          if (last) begin
            s     <= acc_n;
            state <= DONE;
          end else begin
            acc <= acc_n;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign ocupado = (state == CALC);
  assign pronto  = (state == DONE);

endmodule

// File: tb/tb_multiplica_galois_seq.sv
// Bench for multiplica_galois_seq: 8-bit AES instance plus a 4-bit (POLY=3) instance.
// Expected products and completion cycles are queued at launch and checked on pronto.
module tb_multiplica_galois_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       inicio8 = 1'b0;
  logic [7:0] e8 = '0, c8 = '0, s8;
  logic       ocupado8, pronto8;
  logic       inicio4 = 1'b0;
  logic [3:0] e4 = '0, c4 = '0, s4;
  logic       ocupado4, pronto4;

  always #5 clk = ~clk;

  multiplica_galois_seq #(.WIDTH(8), .POLY(8'h1B)) dut8 (
    .clk(clk), .rst(rst), .inicio(inicio8), .e(e8), .c(c8),
    .s(s8), .ocupado(ocupado8), .pronto(pronto8)
  );

  multiplica_galois_seq #(.WIDTH(4), .POLY(4'h3)) dut4 (
    .clk(clk), .rst(rst), .inicio(inicio4), .e(e4), .c(c4),
    .s(s4), .ocupado(ocupado4), .pronto(pronto4)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned cyc   = 0;

  typedef struct { logic [7:0] s; int unsigned at; } exp_t;
  typedef struct { logic [7:0] e; logic [7:0] c; logic [7:0] s; } vec_t;

  exp_t q8[$];
  exp_t q4[$];
  vec_t tv[8];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: full carry-less product, then polynomial long division.
  function automatic logic [31:0] gf_mul(input logic [31:0] x, input logic [31:0] y,
                                         input int w, input logic [31:0] poly);
    logic [31:0] p, m;
    p = '0;
    for (int i = 0; i < w; i++)
      if (y[i]) p = p ^ (x << i);
    m = (32'd1 << w) | poly;
    for (int k = 2 * w - 2; k >= w; k--)
      if (p[k]) p = p ^ (m << (k - w));
    return p & ((32'd1 << w) - 32'd1);
  endfunction

  function automatic int unsigned n_steps(input logic [7:0] cv, input int w);
    int unsigned n;
    n = w;
`ifdef MULTIPLICA_GALOIS_EARLY_EN
    n = 1;
    for (int i = 0; i < w; i++)
      if (cv[i]) n = i + 1;
`endif
    return n;
  endfunction

  always @(negedge clk) begin : mon8
    exp_t x;
    if (rst === 1'b0 && pronto8 === 1'b1) begin
      if (q8.size() == 0) check("pronto8_unexpected", 32'd1, 32'd0);
      else begin
        x = q8.pop_front();
        check("s8", {24'd0, s8}, {24'd0, x.s});
        check("pronto8_cycle", cyc, x.at);
        check("ocupado8_in_done", {31'd0, ocupado8}, 32'd0);
      end
    end
  end

  always @(negedge clk) begin : mon4
    exp_t x;
    if (rst === 1'b0 && pronto4 === 1'b1) begin
      if (q4.size() == 0) check("pronto4_unexpected", 32'd1, 32'd0);
      else begin
        x = q4.pop_front();
        check("s4", {28'd0, s4}, {24'd0, x.s});
        check("pronto4_cycle", cyc, x.at);
      end
    end
  end

  // Called at a negedge with the DUT idle; returns at the negedge after the accepting edge.
  task automatic launch8(input logic [7:0] ev, input logic [7:0] cv, input logic [7:0] sv);
    e8 = ev; c8 = cv; inicio8 = 1'b1;
    q8.push_back('{s: sv, at: cyc + n_steps(cv, 8) + 1});
    @(posedge clk); @(negedge clk);
    inicio8 = 1'b0;
    check("ocupado8_after_accept", {31'd0, ocupado8}, 32'd1);
  endtask

  task automatic launch4(input logic [3:0] ev, input logic [3:0] cv, input logic [3:0] sv);
    e4 = ev; c4 = cv; inicio4 = 1'b1;
    q4.push_back('{s: {4'd0, sv}, at: cyc + n_steps({4'd0, cv}, 4) + 1});
    @(posedge clk); @(negedge clk);
    inicio4 = 1'b0;
  endtask

  // Waits for all queued results, then one more cycle so the DUT is back in IDLE.
  task automatic drain8(input int bound);
    for (int i = 0; i < bound && q8.size() != 0; i++) @(negedge clk);
    if (q8.size() != 0) begin
      check("drain8_timeout", q8.size(), 32'd0);
      q8.delete();
    end
    inicio8 = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain4(input int bound);
    for (int i = 0; i < bound && q4.size() != 0; i++) @(negedge clk);
    if (q4.size() != 0) begin
      check("drain4_timeout", q4.size(), 32'd0);
      q4.delete();
    end
    inicio4 = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int unsigned t0;
    tv[0] = '{e: 8'h50, c: 8'h0E, s: 8'h4D};
    tv[1] = '{e: 8'h41, c: 8'h0B, s: 8'hFD};
    tv[2] = '{e: 8'h4C, c: 8'h0D, s: 8'h31};
    tv[3] = '{e: 8'h41, c: 8'h09, s: 8'h7F};
    tv[4] = '{e: 8'h02, c: 8'h80, s: 8'h1B};
    tv[5] = '{e: 8'h5A, c: 8'h00, s: 8'h00};
    tv[6] = '{e: 8'h57, c: 8'h83, s: 8'hC1};
    tv[7] = '{e: 8'h57, c: 8'h13, s: 8'hFE};

    repeat (2) @(negedge clk);
    check("reset_s8", {24'd0, s8}, 32'd0);
    check("reset_ocupado8", {31'd0, ocupado8}, 32'd0);
    check("reset_pronto8", {31'd0, pronto8}, 32'd0);
    check("reset_s4", {28'd0, s4}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      launch8(tv[i].e, tv[i].c, tv[i].s);
      drain8(40);
    end

    // Reset mid-CALC: outputs clear at once and the aborted op never completes.
    launch8(8'h50, 8'h0E, 8'h4D);
    @(negedge clk);
    rst = 1'b1;
    q8.delete();
    #1;
    check("midreset_s8", {24'd0, s8}, 32'd0);
    check("midreset_ocupado8", {31'd0, ocupado8}, 32'd0);
    check("midreset_pronto8", {31'd0, pronto8}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    launch8(8'h41, 8'h09, 8'h7F);
    drain8(40);

    // Operands and inicio churn during CALC must not affect the captured op.
    e8 = 8'h4C; c8 = 8'h0D; inicio8 = 1'b1;
    q8.push_back('{s: 8'h31, at: cyc + n_steps(8'h0D, 8) + 1});
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      inicio8 = ~inicio8;
      e8 = 8'($urandom);
      c8 = 8'($urandom);
    end
    @(negedge clk);
    inicio8 = 1'b0;
    drain8(40);
    repeat (12) @(negedge clk);

    // inicio held high: second op accepted N+2 cycles after the first.
    t0 = cyc;
    e8 = 8'h41; c8 = 8'h0B; inicio8 = 1'b1;
    q8.push_back('{s: 8'hFD, at: t0 + n_steps(8'h0B, 8) + 1});
    q8.push_back('{s: 8'h1B, at: t0 + n_steps(8'h0B, 8) + 2 + n_steps(8'h80, 8) + 1});
    @(posedge clk); @(negedge clk);
    e8 = 8'h02; c8 = 8'h80;
    drain8(60);
    repeat (12) @(negedge clk);

    // 4-bit field: spec constants, then the full operand sweep against the model.
    launch4(4'h8, 4'h2, 4'h3);
    drain4(30);
    launch4(4'hF, 4'hF, 4'hA);
    drain4(30);
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        launch4(4'(x), 4'(y), 4'(gf_mul(32'(x), 32'(y), 4, 32'h3)));
        drain4(30);
      end
    end

    check("q8_empty_at_end", q8.size(), 32'd0);
    check("q4_empty_at_end", q4.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
